// File: rtl/keypad_code_player.sv
// keypad_code_player: replays a multi-digit BCD code as one-hot keypad presses,
// then samples the lock's button_on response and reports pass/fail/err.
// Latency: a valid code accepted at edge k shows its first press in cycle k+1,
// and done is high in cycle k+1+DIGITS*(HOLD_CYC+GAP_CYC)+WAIT_CYC. An invalid
// code gives done in cycle k+1.
// Backpressure: none. start is only honoured in IDLE and is dropped while busy.
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   start, code       run request and BCD code (MS nibble is played first)
//   button_on         lock response; only sampled during the response window
//   num               one-hot keypad bus (bit d = digit d pressed)
//   busy, done        run in progress / one-cycle end-of-run pulse
//   pass, err         result of the last run; held until the next accepted start
module keypad_code_player #(
  parameter int DIGITS   = 3,
  parameter int HOLD_CYC = 5,
  parameter int GAP_CYC  = 5,
  parameter int WAIT_CYC = 10,
  parameter int CNT_W    = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   code,
  input  logic                  button_on,
  output logic [9:0]            num,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  err
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS,
    S_RELEASE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    timer_q, timer_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  // Digits still to be played, left-aligned so the next one is always the top nibble.
  logic [4*DIGITS-1:0] sh_q, sh_d;
  logic [9:0]          num_q, num_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                err_q, err_d;

  function automatic logic [9:0] onehot(input logic [3:0] d);
    onehot = 10'd1 << d;
  endfunction

  function automatic logic has_bad_digit(input logic [4*DIGITS-1:0] c);
    has_bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (c[4*i +: 4] > 4'd9) has_bad_digit = 1'b1;
    end
  endfunction

  // Outputs are computed for the next state so that num/busy/done are registered
  // yet line up exactly with the state they belong to.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    num_d   = num_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pass_d  = 1'b0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          timer_d = '0;
          idx_d   = '0;
          if (has_bad_digit(code)) begin
            state_d = S_DONE;
            err_d   = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = S_PRESS;
            num_d   = onehot(code[4*DIGITS-1 -: 4]);
            sh_d    = code << 4;
          end
        end
      end

      S_PRESS: begin
        if (timer_q == CNT_W'(HOLD_CYC - 1)) begin
          state_d = S_RELEASE;
          timer_d = '0;
          num_d   = '0;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end

      S_RELEASE: begin
        if (timer_q == CNT_W'(GAP_CYC - 1)) begin
          timer_d = '0;
          if (idx_q == IDX_W'(DIGITS - 1)) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_PRESS;
            idx_d   = idx_q + IDX_W'(1);
            num_d   = onehot(sh_q[4*DIGITS-1 -: 4]);
            sh_d    = sh_q << 4;
          end
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end

      S_WAIT: begin
        // Any high sample in the window unlocks; the final window cycle counts too.
        pass_d = pass_q | button_on;
        if (timer_q == CNT_W'(WAIT_CYC - 1)) begin
          state_d = S_DONE;
          timer_d = '0;
          done_d  = 1'b1;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        num_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      num_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      num_q   <= num_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
    end
  end

  assign num  = num_q;
  assign busy = busy_q;
  assign done = done_q;
  assign pass = pass_q;
  assign err  = err_q;

endmodule
